touch_scan_ctrl: RTL



---
 rtl/touch_scan_ctrl_pkg.sv | 23 ++
 rtl/touch_scan_ctrl_key_debounce.sv | 54 +++++
 rtl/touch_scan_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/touch_scan_ctrl_pkg.sv
// Shared scan FSM encoding and width helpers for the touch-key scanner.
package touch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_ADVANCE = 2'd3
    } scan_state_t;

    function automatic int idx_width(input int num_keys);
        return (num_keys > 2) ? $clog2(num_keys) : 1;
    endfunction

    function automatic int tick_width(input int tick_div);
        return $clog2(tick_div);
    endfunction

    function automatic int dbc_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/touch_scan_ctrl_key_debounce.sv
// Per-key debouncer: flips state after DEBOUNCE consecutive differing samples.
// TOUCH_RELEASE_EVT_EN adds the fall pulse output.
module key_debounce
    import touch_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic strobe,
    input  logic sample,
    output logic state,
`ifdef TOUCH_RELEASE_EVT_EN
    output logic fall,
`endif
    output logic rise
);

    localparam int CW = dbc_width(DEBOUNCE);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
`ifdef TOUCH_RELEASE_EVT_EN
            fall  <= 1'b0;
`endif
        end else begin
            rise <= 1'b0;
`ifdef TOUCH_RELEASE_EVT_EN
            fall <= 1'b0;
`endif
            if (strobe) begin
                if (sample == state) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE - 1)) begin
                    // last differing sample: flip and restart the count
                    cnt   <= '0;
                    state <= sample;
                    rise  <= sample;
`ifdef TOUCH_RELEASE_EVT_EN
                    fall  <= ~sample;
`endif
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/touch_scan_ctrl.sv
// Time-multiplexed touch-key scanner with per-key debounce.
// TOUCH_RELEASE_EVT_EN adds the RELEASE_EVENT output.
//
// state      | meaning
// ST_IDLE    | not scanning, SEL=0
// ST_SETTLE  | pad selected, timebase counting settle time
// ST_SAMPLE  | capture SENSE into the selected key's debouncer
// ST_ADVANCE | step to next pad, SCAN_DONE after the last one
module touch_scan_ctrl
    import touch_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int TICK_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                ENABLE,
    input  logic                SENSE,
    output logic [NUM_KEYS-1:0] SEL,
    output logic [NUM_KEYS-1:0] KEY_STATE,
    output logic [NUM_KEYS-1:0] KEY_EVENT,
`ifdef TOUCH_RELEASE_EVT_EN
    output logic [NUM_KEYS-1:0] RELEASE_EVENT,
`endif
    output logic                SCAN_DONE,
    output logic                BUSY
);

    localparam int IW = idx_width(NUM_KEYS);
    localparam int TW = tick_width(TICK_DIV);

    scan_state_t   state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [TW-1:0] tbase, tbase_nx;
    logic          last_key;
    logic          strobe;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            tbase <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            tbase <= tbase_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        tbase_nx  = tbase;
        last_key  = (idx == IW'(NUM_KEYS - 1));
        BUSY      = (state != ST_IDLE);
        SEL       = BUSY ? (NUM_KEYS'(1) << idx) : '0;
        // an aborted slot must neither sample nor report completion
        strobe    = ENABLE && (state == ST_SAMPLE);
        SCAN_DONE = ENABLE && (state == ST_ADVANCE) && last_key;

        if (!ENABLE) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            tbase_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_SETTLE;
                    idx_nx   = '0;
                    tbase_nx = '0;
                end
                ST_SETTLE: begin
                    if (tbase == TW'(TICK_DIV - 1)) begin
                        tbase_nx = '0;
                        state_nx = ST_SAMPLE;
                    end else begin
                        tbase_nx = tbase + TW'(1);
                    end
                end
                ST_SAMPLE: state_nx = ST_ADVANCE;
                ST_ADVANCE: begin
                    state_nx = ST_SETTLE;
                    idx_nx   = last_key ? '0 : idx + IW'(1);
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_dbc (
            .CLK    (CLK),
            .RST_n  (RST_n),
            .strobe (strobe && (idx == IW'(k))),
            .sample (SENSE),
            .state  (KEY_STATE[k]),
`ifdef TOUCH_RELEASE_EVT_EN
            .fall   (RELEASE_EVENT[k]),
`endif
            .rise   (KEY_EVENT[k])
        );
    end

endmodule
